// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, reset PC, opcodes and fetch-queue types
package pipe_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

    // Major opcode lives in the top nibble of every instruction word
    typedef enum logic [3:0] {
        OP_RTYPE       = 4'b0000,
        OP_ADDI        = 4'b0001,
        OP_LOAD        = 4'b0010,
        OP_STORE       = 4'b0011,
        OP_BRANCH      = 4'b0100,
        OP_JUMP        = 4'b0101,
        OP_RIGHT_SHIFT = 4'b0110,
        OP_LEFT_SHIFT  = 4'b0111
    } opcode_e;

    // Occupancy class of the instruction queue
    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;

    // One queue slot: the fetched word and the address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic opcode_e opcode_of(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[INSTR_W-1:INSTR_W-4]);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous instruction FIFO with push/pop/flush
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output q_state_e                   state_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    q_state_e      state_q;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    // Next occupancy: flush wins, otherwise push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared by reset or flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (pop_ok) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                if (push_ok) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
            end
        end
    end

    // Slot storage; contents are never visible while empty so no reset needed
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Occupancy state machine tracking EMPTY / PARTIAL / FULL
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Q_EMPTY;
        end else if (flush_i) begin
            state_q <= Q_EMPTY;
        end else if (count_d == '0) begin
            state_q <= Q_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_q <= Q_FULL;
        end else begin
            state_q <= Q_PARTIAL;
        end
    end

    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign state_o = state_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single in-flight request, queue to decode
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                QDEPTH   = 2
) (
    input  logic               CLK,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [ADDR_W-1:0] inflight_pc_d;
    logic              inflight_q;
    logic              inflight_d;
    logic [CW-1:0]     q_count;
    q_state_e          q_state;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;
    logic              push;
    logic              pop;
    logic [3:0]        occ_after_pop;

    // A response is only kept if no redirect is squashing it this cycle
    assign push       = inflight_q && !redirect_valid;
    assign push_entry = '{instr: imem_rdata, pc: inflight_pc_q};

    assign id_valid = (q_state != Q_EMPTY) && !redirect_valid;
    assign pop      = id_valid && id_ready;

    // Reserve a slot for every word already queued or on its way back
    assign occ_after_pop = 4'(q_count) + {3'b000, inflight_q} - {3'b000, pop};
    assign imem_req      = !reset && !redirect_valid && (occ_after_pop < 4'(QDEPTH));
    assign imem_addr     = pc_q;

    assign id_instr = q_head.instr;
    assign id_pc    = q_head.pc;

    // Next fetch PC and in-flight tracking; redirect overrides issuing
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    // PC and in-flight registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk_i        (CLK),
        .rst_i        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_o       (q_head),
        .count_o      (q_count),
        .state_o      (q_state)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(
        .RESET_PC (8'h00),
        .QDEPTH   (2)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h1044;
            8'h01:   return 16'h1081;
            8'h02:   return 16'h00CA;
            default: return {8'hC3, a};
        endcase
    endfunction

    // Instruction memory: word for the requested address appears one cycle later
    always @(posedge CLK) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 16'hDEAD;
    end

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        id_ready       = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        id_ready       = 1'b1;
        #1;
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", imem_req); end
        vec_cnt++; if (imem_addr !== 8'h00) begin err_cnt++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        vec_cnt++; if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        vec_cnt++; if (id_instr !== 16'h0000) begin err_cnt++; $display("FAIL reset_instr: got %h want 0000", id_instr); end
        vec_cnt++; if (id_pc !== 8'h00) begin err_cnt++; $display("FAIL reset_pc: got %h want 00", id_pc); end
        @(negedge CLK);
        #1;
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req_held: got %b want 0", imem_req); end
    endtask

    task automatic test_stream();
        logic exp_valid;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            exp_valid = (c >= 2);
            vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL stream_req c%0d: got %b want 1", c, imem_req); end
            vec_cnt++; if (imem_addr !== 8'(c)) begin err_cnt++; $display("FAIL stream_addr c%0d: got %h want %h", c, imem_addr, 8'(c)); end
            vec_cnt++; if (id_valid !== exp_valid) begin err_cnt++; $display("FAIL stream_valid c%0d: got %b want %b", c, id_valid, exp_valid); end
            if (exp_valid) begin
                vec_cnt++; if (id_pc !== 8'(c - 2)) begin err_cnt++; $display("FAIL stream_pc c%0d: got %h want %h", c, id_pc, 8'(c - 2)); end
                vec_cnt++; if (id_instr !== mem_word(8'(c - 2))) begin err_cnt++; $display("FAIL stream_instr c%0d: got %h want %h", c, id_instr, mem_word(8'(c - 2))); end
            end else begin
                vec_cnt++; if (id_instr !== 16'h0000) begin err_cnt++; $display("FAIL stream_empty_instr c%0d: got %h want 0000", c, id_instr); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_backpressure();
        logic       exp_req;
        logic [7:0] exp_addr;
        logic [7:0] exp_pc;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            id_ready = (c >= 5);
            #1;
            exp_req  = (c < 2) || (c >= 5);
            exp_addr = (c < 2) ? 8'(c) : 8'(c - 3);
            exp_pc   = (c < 5) ? 8'h00 : 8'(c - 5);
            vec_cnt++; if (imem_req !== exp_req) begin err_cnt++; $display("FAIL bp_req c%0d: got %b want %b", c, imem_req, exp_req); end
            if (exp_req) begin
                vec_cnt++; if (imem_addr !== exp_addr) begin err_cnt++; $display("FAIL bp_addr c%0d: got %h want %h", c, imem_addr, exp_addr); end
            end
            vec_cnt++; if (id_valid !== (c >= 2)) begin err_cnt++; $display("FAIL bp_valid c%0d: got %b want %b", c, id_valid, (c >= 2)); end
            if (c >= 2) begin
                vec_cnt++; if (id_pc !== exp_pc) begin err_cnt++; $display("FAIL bp_pc c%0d: got %h want %h", c, id_pc, exp_pc); end
                vec_cnt++; if (id_instr !== mem_word(exp_pc)) begin err_cnt++; $display("FAIL bp_instr c%0d: got %h want %h", c, id_instr, mem_word(exp_pc)); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_redirect();
        logic [8:0] e_req   = 9'b111101111;
        logic [8:0] e_valid = 9'b110001100;
        logic [8:0] e_redir = 9'b000010000;
        logic [7:0] e_addr [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        logic [7:0] e_pc   [9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0E};
        do_reset();
        id_ready    = 1'b1;
        redirect_pc = 8'h0D;
        for (int c = 0; c < 9; c++) begin
            redirect_valid = e_redir[c];
            #1;
            vec_cnt++; if (imem_req !== e_req[c]) begin err_cnt++; $display("FAIL redir_req c%0d: got %b want %b", c, imem_req, e_req[c]); end
            vec_cnt++; if (imem_addr !== e_addr[c]) begin err_cnt++; $display("FAIL redir_addr c%0d: got %h want %h", c, imem_addr, e_addr[c]); end
            vec_cnt++; if (id_valid !== e_valid[c]) begin err_cnt++; $display("FAIL redir_valid c%0d: got %b want %b", c, id_valid, e_valid[c]); end
            if (e_valid[c]) begin
                vec_cnt++; if (id_pc !== e_pc[c]) begin err_cnt++; $display("FAIL redir_pc c%0d: got %h want %h", c, id_pc, e_pc[c]); end
                vec_cnt++; if (id_instr !== mem_word(e_pc[c])) begin err_cnt++; $display("FAIL redir_instr c%0d: got %h want %h", c, id_instr, mem_word(e_pc[c])); end
            end else if (!e_redir[c]) begin
                vec_cnt++; if (id_instr !== 16'h0000) begin err_cnt++; $display("FAIL redir_empty_instr c%0d: got %h want 0000", c, id_instr); end
            end
            @(negedge CLK);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [5:0] e_req   = 6'b111110;
        logic [5:0] e_valid = 6'b111000;
        logic [5:0] e_redir = 6'b000001;
        logic [7:0] e_addr [6] = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        logic [7:0] e_pc   [6] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'h00};
        do_reset();
        id_ready    = 1'b1;
        redirect_pc = 8'hFE;
        for (int c = 0; c < 6; c++) begin
            redirect_valid = e_redir[c];
            #1;
            vec_cnt++; if (imem_req !== e_req[c]) begin err_cnt++; $display("FAIL wrap_req c%0d: got %b want %b", c, imem_req, e_req[c]); end
            vec_cnt++; if (imem_addr !== e_addr[c]) begin err_cnt++; $display("FAIL wrap_addr c%0d: got %h want %h", c, imem_addr, e_addr[c]); end
            vec_cnt++; if (id_valid !== e_valid[c]) begin err_cnt++; $display("FAIL wrap_valid c%0d: got %b want %b", c, id_valid, e_valid[c]); end
            if (e_valid[c]) begin
                vec_cnt++; if (id_pc !== e_pc[c]) begin err_cnt++; $display("FAIL wrap_pc c%0d: got %h want %h", c, id_pc, e_pc[c]); end
                vec_cnt++; if (id_instr !== mem_word(e_pc[c])) begin err_cnt++; $display("FAIL wrap_instr c%0d: got %h want %h", c, id_instr, mem_word(e_pc[c])); end
            end
            @(negedge CLK);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_redirect_full_pop();
        logic [7:0] e_ready = 8'b11110000;
        logic [7:0] e_redir = 8'b00010000;
        logic [7:0] e_req   = 8'b11100011;
        logic [7:0] e_valid = 8'b10001100;
        logic [7:0] e_addr [8] = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h40, 8'h41, 8'h42};
        logic [7:0] e_pc   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
        do_reset();
        redirect_pc = 8'h40;
        for (int c = 0; c < 8; c++) begin
            id_ready       = e_ready[c];
            redirect_valid = e_redir[c];
            #1;
            vec_cnt++; if (imem_req !== e_req[c]) begin err_cnt++; $display("FAIL fullpop_req c%0d: got %b want %b", c, imem_req, e_req[c]); end
            vec_cnt++; if (imem_addr !== e_addr[c]) begin err_cnt++; $display("FAIL fullpop_addr c%0d: got %h want %h", c, imem_addr, e_addr[c]); end
            vec_cnt++; if (id_valid !== e_valid[c]) begin err_cnt++; $display("FAIL fullpop_valid c%0d: got %b want %b", c, id_valid, e_valid[c]); end
            if (e_valid[c]) begin
                vec_cnt++; if (id_pc !== e_pc[c]) begin err_cnt++; $display("FAIL fullpop_pc c%0d: got %h want %h", c, id_pc, e_pc[c]); end
                vec_cnt++; if (id_instr !== mem_word(e_pc[c])) begin err_cnt++; $display("FAIL fullpop_instr c%0d: got %h want %h", c, id_instr, mem_word(e_pc[c])); end
            end else if (!e_redir[c]) begin
                vec_cnt++; if (id_instr !== 16'h0000) begin err_cnt++; $display("FAIL fullpop_empty_instr c%0d: got %h want 0000", c, id_instr); end
                vec_cnt++; if (id_pc !== 8'h00) begin err_cnt++; $display("FAIL fullpop_empty_pc c%0d: got %h want 00", c, id_pc); end
            end
            @(negedge CLK);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        id_ready = 1'b1;
        repeat (5) @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL mrst_req: got %b want 0", imem_req); end
        vec_cnt++; if (imem_addr !== 8'h00) begin err_cnt++; $display("FAIL mrst_addr: got %h want 00", imem_addr); end
        vec_cnt++; if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL mrst_valid: got %b want 0", id_valid); end
        vec_cnt++; if (id_instr !== 16'h0000) begin err_cnt++; $display("FAIL mrst_instr: got %h want 0000", id_instr); end
        vec_cnt++; if (id_pc !== 8'h00) begin err_cnt++; $display("FAIL mrst_pc: got %h want 00", id_pc); end
        @(negedge CLK);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL mrst_post_req c%0d: got %b want 1", c, imem_req); end
            vec_cnt++; if (imem_addr !== 8'(c)) begin err_cnt++; $display("FAIL mrst_post_addr c%0d: got %h want %h", c, imem_addr, 8'(c)); end
            vec_cnt++; if (id_valid !== (c >= 2)) begin err_cnt++; $display("FAIL mrst_post_valid c%0d: got %b want %b", c, id_valid, (c >= 2)); end
            if (c >= 2) begin
                vec_cnt++; if (id_pc !== 8'(c - 2)) begin err_cnt++; $display("FAIL mrst_post_pc c%0d: got %h want %h", c, id_pc, 8'(c - 2)); end
                vec_cnt++; if (id_instr !== mem_word(8'(c - 2))) begin err_cnt++; $display("FAIL mrst_post_instr c%0d: got %h want %h", c, id_instr, mem_word(8'(c - 2))); end
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_redirect_full_pop();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
